proc_stall_detector: RTL and testbench

- Per-process deadlock detector for the C/RTL co-simulation testbench.
- One instance sits on each dataflow process (e.g. test_pattern1.Loop_loop_height1_pr_U0, test_pattern1.Mat2AXIvideo_U0) and drives one bit of the deadlock report unit's dl_in_vec.
- It watches the process's per-channel blk_n signals and declares a stall once the same blocking set persists for STALL_THRESH cycles.
- It then circulates a token to the peer processes it waits on, and asserts dl_out when its own token returns, which closes a dependence cycle.

---
 rtl/proc_stall_detector_pkg.sv | 56 +++++
 rtl/proc_stall_detector_stall_counter.sv | 28 ++
 rtl/proc_stall_detector.sv | 158 +++++++++++++++
 tb/tb_proc_stall_detector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_stall_detector_pkg.sv
// Shared state encoding and combinational helpers for the dataflow stall detector.
// Vector arguments are sized to generous maxima; callers zero-extend and truncate with casts.
package proc_stall_detector_pkg;

    localparam int MAX_PROC = 16;
    localparam int MAX_CHAN = 16;
    localparam int MAX_MAP  = MAX_PROC * MAX_PROC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        LAUNCH  = 2'd2,
        STALLED = 2'd3
    } state_e;

    function automatic logic [MAX_PROC-1:0] onehot(input int id, input int proc_num);
        logic [MAX_PROC-1:0] v;
        v = '0;
        if (id >= 0 && id < proc_num) v[id] = 1'b1;
        return v;
    endfunction

    // Peers reached through blocked channels; a channel looping back to ourselves is not a dependence.
    function automatic logic [MAX_PROC-1:0] peer_or(input logic [MAX_CHAN-1:0] blk_set,
                                                    input logic [MAX_MAP-1:0]  peer_map,
                                                    input int chan_num, input int proc_num,
                                                    input int self_id);
        logic [MAX_PROC-1:0] v;
        v = '0;
        for (int c = 0; c < chan_num; c++)
            for (int p = 0; p < proc_num; p++)
                if (blk_set[c] && peer_map[c*proc_num + p]) v[p] = 1'b1;
        if (self_id >= 0 && self_id < proc_num) v[self_id] = 1'b0;
        return v;
    endfunction

    // Lowest valid token index whose origin is not ours, or -1 when there is none.
    function automatic int first_foreign(input logic [MAX_PROC-1:0] vld,
                                         input logic [MAX_MAP-1:0]  origins,
                                         input logic [MAX_PROC-1:0] self,
                                         input int proc_num);
        int idx;
        idx = -1;
        for (int j = proc_num - 1; j >= 0; j--) begin
            if (vld[j]) begin
                logic same;
                same = 1'b1;
                for (int p = 0; p < proc_num; p++)
                    if (origins[j*proc_num + p] != self[p]) same = 1'b0;
                if (!same) idx = j;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/proc_stall_detector_stall_counter.sv
// Saturating run-length counter for one blocking pattern; restarts at 1 when the pattern changes.
module stall_counter #(
    parameter int THRESH = 1024,
    parameter int CNT_W  = $clog2(THRESH) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_start,
    input  logic i_inc,
    output logic o_hit
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || i_clear)
            r_count <= '0;
        else if (i_start)
            r_count <= CNT_W'(1);
        else if (i_inc && r_count != '1)
            r_count <= r_count + 1'b1;
    end

    assign o_hit = (r_count == CNT_W'(THRESH - 1));

endmodule

// File: rtl/proc_stall_detector.sv
// Per-process deadlock detector: declares a stall on a persistent blocking set, launches a
// token to the peers it waits on, forwards foreign tokens and flags a closed dependence cycle.
module proc_stall_detector
    import proc_stall_detector_pkg::*;
#(
    parameter int                           PROC_NUM     = 2,
    parameter int                           PROC_ID      = 0,
    parameter int                           CHAN_NUM     = 3,
    parameter logic [CHAN_NUM*PROC_NUM-1:0] CHAN_PEER    = 6'b10_10_10,
    parameter int                           STALL_THRESH = 1024,
    parameter int                           CNT_W        = $clog2(STALL_THRESH) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         proc_active,
    input  logic [CHAN_NUM-1:0]          chan_blk_n,
    input  logic [PROC_NUM-1:0]          in_tok_vld,
    input  logic [PROC_NUM*PROC_NUM-1:0] in_tok_origin,
    input  logic                         token_clear,
    output logic                         out_tok_vld,
    output logic [PROC_NUM-1:0]          out_tok_dst,
    output logic [PROC_NUM-1:0]          out_tok_origin,
    output logic                         dl_out,
    output logic [PROC_NUM-1:0]          dep_vec
);

    state_e                r_state, w_state_nxt;
    logic [CHAN_NUM-1:0]   r_blk_reg, w_blk_nxt;
    logic                  r_tok_vld, w_tok_vld_nxt;
    logic [PROC_NUM-1:0]   r_tok_dst, w_tok_dst_nxt;
    logic [PROC_NUM-1:0]   r_tok_org, w_tok_org_nxt;
    logic                  r_dl, w_dl_nxt;
    logic [PROC_NUM-1:0]   r_dep, w_dep_nxt;

    logic [CHAN_NUM-1:0]   w_blk_set;
    logic                  w_blocked, w_same;
    logic [PROC_NUM-1:0]   w_self, w_dep_calc, w_fwd_origin;
    logic                  w_own_hit, w_fwd_hit;
    int                    w_fwd_idx;
    logic                  w_cnt_clear, w_cnt_start, w_cnt_inc, w_cnt_hit;

    assign w_blk_set  = ~chan_blk_n;
    assign w_blocked  = proc_active & (|w_blk_set);
    assign w_same     = (w_blk_set == r_blk_reg);
    assign w_self     = PROC_NUM'(onehot(PROC_ID, PROC_NUM));
    assign w_dep_calc = PROC_NUM'(peer_or(MAX_CHAN'(r_blk_reg), MAX_MAP'(CHAN_PEER),
                                          CHAN_NUM, PROC_NUM, PROC_ID));
    assign w_fwd_idx  = first_foreign(MAX_PROC'(in_tok_vld), MAX_MAP'(in_tok_origin),
                                      MAX_PROC'(w_self), PROC_NUM);
    assign w_fwd_hit  = (w_fwd_idx >= 0);

    always_comb begin
        w_own_hit    = 1'b0;
        w_fwd_origin = '0;
        for (int j = 0; j < PROC_NUM; j++) begin
            if (in_tok_vld[j] && in_tok_origin[j*PROC_NUM +: PROC_NUM] == w_self)
                w_own_hit = 1'b1;
            if (j == w_fwd_idx)
                w_fwd_origin = in_tok_origin[j*PROC_NUM +: PROC_NUM];
        end
    end

    stall_counter #(.THRESH(STALL_THRESH), .CNT_W(CNT_W)) u_stall_counter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_cnt_clear),
        .i_start (w_cnt_start),
        .i_inc   (w_cnt_inc),
        .o_hit   (w_cnt_hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_blk_reg <= '0;
            r_tok_vld <= 1'b0;
            r_tok_dst <= '0;
            r_tok_org <= '0;
            r_dl      <= 1'b0;
            r_dep     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_blk_reg <= w_blk_nxt;
            r_tok_vld <= w_tok_vld_nxt;
            r_tok_dst <= w_tok_dst_nxt;
            r_tok_org <= w_tok_org_nxt;
            r_dl      <= w_dl_nxt;
            r_dep     <= w_dep_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_blk_nxt     = r_blk_reg;
        w_tok_vld_nxt = 1'b0;
        w_tok_dst_nxt = r_tok_dst;
        w_tok_org_nxt = r_tok_org;
        w_dl_nxt      = r_dl;
        w_dep_nxt     = r_dep;
        w_cnt_clear   = 1'b0;
        w_cnt_start   = 1'b0;
        w_cnt_inc     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_blocked) begin
                    w_state_nxt = COUNT;
                    w_cnt_start = 1'b1;
                    w_blk_nxt   = w_blk_set;
                end
            end
            COUNT: begin
                if (!w_blocked) begin
                    w_state_nxt = IDLE;
                    w_cnt_clear = 1'b1;
                end else if (!w_same) begin
                    w_cnt_start = 1'b1;
                    w_blk_nxt   = w_blk_set;
                end else if (w_cnt_hit) begin
                    w_state_nxt = LAUNCH;
                    w_dep_nxt   = w_dep_calc;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            LAUNCH: begin
                w_state_nxt   = STALLED;
                w_tok_vld_nxt = 1'b1;
                w_tok_dst_nxt = r_dep;
                w_tok_org_nxt = w_self;
            end
            STALLED: begin
                // A changed or vanished blocking set means the stall was not a deadlock.
                if (!w_blocked || !w_same) begin
                    w_state_nxt = IDLE;
                    w_cnt_clear = 1'b1;
                    w_dl_nxt    = 1'b0;
                    w_dep_nxt   = '0;
                end else begin
                    if (w_own_hit) w_dl_nxt = 1'b1;
                    if (w_fwd_hit && !token_clear) begin
                        w_tok_vld_nxt = 1'b1;
                        w_tok_dst_nxt = r_dep;
                        w_tok_org_nxt = w_fwd_origin;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_tok_vld    = r_tok_vld;
    assign out_tok_dst    = r_tok_dst;
    assign out_tok_origin = r_tok_org;
    assign dl_out         = r_dl;
    assign dep_vec        = r_dep;

endmodule

// File: tb/tb_proc_stall_detector.sv
// Bench for proc_stall_detector: two instances (PROC_ID 0 and 1) share stimulus and are compared
// every cycle against a run-length model, with directed literal checks pinning the model.
module tb_proc_stall_detector;

    localparam int PN = 2;
    localparam int CN = 3;
    localparam int ON = PN * PN;
    localparam int TH = 8;
    localparam logic [CN*PN-1:0] PEER0 = 6'b10_10_10;
    localparam logic [CN*PN-1:0] PEER1 = 6'b01_01_01;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          proc_active = 1'b0;
    logic [CN-1:0] chan_blk_n = '1;
    logic [PN-1:0] in_tok_vld = '0;
    logic [ON-1:0] in_tok_origin = '0;
    logic          token_clear = 1'b0;

    logic          o_vld [2];
    logic [PN-1:0] o_dst [2];
    logic [PN-1:0] o_org [2];
    logic          o_dl  [2];
    logic [PN-1:0] o_dep [2];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    proc_stall_detector #(.PROC_NUM(PN), .PROC_ID(0), .CHAN_NUM(CN), .CHAN_PEER(PEER0),
                          .STALL_THRESH(TH)) u_dut0 (
        .clock(clock), .reset(reset), .proc_active(proc_active), .chan_blk_n(chan_blk_n),
        .in_tok_vld(in_tok_vld), .in_tok_origin(in_tok_origin), .token_clear(token_clear),
        .out_tok_vld(o_vld[0]), .out_tok_dst(o_dst[0]), .out_tok_origin(o_org[0]),
        .dl_out(o_dl[0]), .dep_vec(o_dep[0]));

    proc_stall_detector #(.PROC_NUM(PN), .PROC_ID(1), .CHAN_NUM(CN), .CHAN_PEER(PEER1),
                          .STALL_THRESH(TH)) u_dut1 (
        .clock(clock), .reset(reset), .proc_active(proc_active), .chan_blk_n(chan_blk_n),
        .in_tok_vld(in_tok_vld), .in_tok_origin(in_tok_origin), .token_clear(token_clear),
        .out_tok_vld(o_vld[1]), .out_tok_dst(o_dst[1]), .out_tok_origin(o_org[1]),
        .dl_out(o_dl[1]), .dep_vec(o_dep[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_stalled [2] = '{default: 1'b0};
    bit            m_launch  [2] = '{default: 1'b0};
    int            m_run     [2] = '{default: 0};
    logic [CN-1:0] m_set     [2] = '{default: '0};
    logic [PN-1:0] m_dep     [2] = '{default: '0};
    logic          m_dl      [2] = '{default: 1'b0};
    logic          e_vld     [2] = '{default: 1'b0};
    logic [PN-1:0] e_dst     [2] = '{default: '0};
    logic [PN-1:0] e_org     [2] = '{default: '0};

    function automatic logic [PN-1:0] dep_of(input int k, input logic [CN-1:0] set);
        logic [CN*PN-1:0] map;
        logic [PN-1:0]    r;
        map = (k == 0) ? PEER0 : PEER1;
        r = '0;
        for (int c = 0; c < CN; c++)
            for (int p = 0; p < PN; p++)
                if (set[c] && map[c*PN + p]) r[p] = 1'b1;
        r[k] = 1'b0;
        return r;
    endfunction

    task automatic model_step(input int k);
        logic [CN-1:0] set;
        logic [PN-1:0] self;
        logic [PN-1:0] org;
        bit            blk;
        int            first;
        set   = ~chan_blk_n;
        blk   = proc_active && (set != '0);
        self  = '0;
        self[k] = 1'b1;
        first = -1;
        e_vld[k] = 1'b0;
        if (reset) begin
            m_stalled[k] = 1'b0; m_launch[k] = 1'b0; m_run[k] = 0;
            m_dep[k] = '0; m_dl[k] = 1'b0; e_dst[k] = '0; e_org[k] = '0;
        end else if (m_stalled[k]) begin
            if (!blk || set != m_set[k]) begin
                m_stalled[k] = 1'b0; m_run[k] = 0; m_dl[k] = 1'b0; m_dep[k] = '0;
            end else begin
                for (int j = 0; j < PN; j++) begin
                    if (in_tok_vld[j]) begin
                        org = in_tok_origin[j*PN +: PN];
                        if (org == self) m_dl[k] = 1'b1;
                        else if (first < 0) first = j;
                    end
                end
                if (first >= 0 && !token_clear) begin
                    e_vld[k] = 1'b1;
                    e_dst[k] = m_dep[k];
                    e_org[k] = in_tok_origin[first*PN +: PN];
                end
            end
        end else if (m_launch[k]) begin
            m_launch[k] = 1'b0; m_stalled[k] = 1'b1;
            e_vld[k] = 1'b1; e_dst[k] = m_dep[k]; e_org[k] = self;
        end else if (blk) begin
            if (m_run[k] > 0 && set == m_set[k]) m_run[k]++;
            else begin
                m_run[k] = 1; m_set[k] = set;
            end
            if (m_run[k] == TH) begin
                m_launch[k] = 1'b1; m_dep[k] = dep_of(k, set);
            end
        end else begin
            m_run[k] = 0;
        end
    endtask

    initial forever begin
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d.out_tok_vld", k), 32'(o_vld[k]), 32'(e_vld[k]));
                check($sformatf("dut%0d.dl_out", k), 32'(o_dl[k]), 32'(m_dl[k]));
                check($sformatf("dut%0d.dep_vec", k), 32'(o_dep[k]), 32'(m_dep[k]));
                if (e_vld[k]) begin
                    check($sformatf("dut%0d.out_tok_dst", k), 32'(o_dst[k]), 32'(e_dst[k]));
                    check($sformatf("dut%0d.out_tok_origin", k), 32'(o_org[k]), 32'(e_org[k]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input int k, input string tag);
        check($sformatf("%s dut%0d vld", tag, k), 32'(o_vld[k]), 32'd0);
        check($sformatf("%s dut%0d dst", tag, k), 32'(o_dst[k]), 32'd0);
        check($sformatf("%s dut%0d org", tag, k), 32'(o_org[k]), 32'd0);
        check($sformatf("%s dut%0d dl", tag, k), 32'(o_dl[k]), 32'd0);
        check($sformatf("%s dut%0d dep", tag, k), 32'(o_dep[k]), 32'd0);
    endtask

    task automatic stall_from_idle(input string tag);
        for (int i = 1; i <= TH + 1; i++) begin
            cyc();
            if (i <= TH) begin
                check($sformatf("%s early vld0 c%0d", tag, i), 32'(o_vld[0]), 32'd0);
            end else begin
                check($sformatf("%s launch vld0", tag), 32'(o_vld[0]), 32'd1);
                check($sformatf("%s launch dst0", tag), 32'(o_dst[0]), 32'b10);
                check($sformatf("%s launch org0", tag), 32'(o_org[0]), 32'b01);
                check($sformatf("%s launch vld1", tag), 32'(o_vld[1]), 32'd1);
                check($sformatf("%s launch dst1", tag), 32'(o_dst[1]), 32'b01);
                check($sformatf("%s launch org1", tag), 32'(o_org[1]), 32'b10);
            end
        end
    endtask

    logic [CN-1:0] pat;
    int            hold;

    initial begin
        cyc();
        cyc();
        check_zero(0, "reset");
        check_zero(1, "reset");
        chk_en = 1'b1;

        // Stall detection: token 9 cycles after the first blocked cycle.
        reset = 1'b0; proc_active = 1'b1; chan_blk_n = 3'b110;
        stall_from_idle("stall");
        check("stall dep0", 32'(o_dep[0]), 32'b10);

        // Cycle close on dut0, forward on dut1.
        in_tok_vld = 2'b10; in_tok_origin = 4'b01_00;
        cyc();
        check("close dl0", 32'(o_dl[0]), 32'd1);
        check("close fwd vld1", 32'(o_vld[1]), 32'd1);
        check("close fwd org1", 32'(o_org[1]), 32'b01);
        in_tok_vld = 2'b01; in_tok_origin = 4'b00_01;
        cyc();
        check("hold dl0", 32'(o_dl[0]), 32'd1);
        check("fwd vld1", 32'(o_vld[1]), 32'd1);
        check("fwd dst1", 32'(o_dst[1]), 32'b01);
        check("fwd org1", 32'(o_org[1]), 32'b01);
        token_clear = 1'b1;
        cyc();
        check("clear fwd vld1", 32'(o_vld[1]), 32'd0);
        check("clear keeps dl0", 32'(o_dl[0]), 32'd1);
        token_clear = 1'b0; in_tok_vld = '0; in_tok_origin = '0;

        // Resolution, then a token in IDLE is ignored.
        chan_blk_n = 3'b111;
        cyc();
        check("resolve dl0", 32'(o_dl[0]), 32'd0);
        check("resolve dep0", 32'(o_dep[0]), 32'd0);
        in_tok_vld = 2'b11; in_tok_origin = 4'b10_01;
        cyc();
        check("idle tok vld0", 32'(o_vld[0]), 32'd0);
        check("idle tok dl0", 32'(o_dl[0]), 32'd0);
        in_tok_vld = '0; in_tok_origin = '0;

        // Transient block of 5 cycles never launches.
        chan_blk_n = 3'b110;
        repeat (5) cyc();
        chan_blk_n = 3'b111;
        for (int i = 0; i < TH; i++) begin
            cyc();
            check("transient vld0", 32'(o_vld[0]), 32'd0);
        end

        // Reset at cnt=5, then a full re-count is required.
        chan_blk_n = 3'b110;
        repeat (5) cyc();
        reset = 1'b1;
        cyc();
        check_zero(0, "midreset");
        reset = 1'b0;
        stall_from_idle("recount");

        // Randomised phase with persistent blocking patterns.
        hold = 0;
        pat  = '1;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                pat  = CN'($urandom_range(0, 7));
                hold = $urandom_range(1, 20);
            end
            hold--;
            chan_blk_n    = pat;
            proc_active   = ($urandom_range(0, 15) != 0);
            in_tok_vld    = ($urandom_range(0, 3) == 0) ? PN'($urandom) : '0;
            in_tok_origin = ON'($urandom);
            token_clear   = ($urandom_range(0, 7) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            cyc();
        end

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
